display_scheduler: RTL
======================

# display_scheduler

Shares the two-digit seven-segment display between the RGB mixer channel values. It drives the 8-bit value input of the seven-segment controller. It rotates through the channels on a fixed dwell time. When a channel changes (encoder activity), that channel pre-empts the rotation for a hold period, and simultaneous changes are served in round-robin order.

## Interface
- N_CH, 3: number of channels; legal 2..8.
- DWELL_CYCLES, 12_000_000: clock cycles each channel is shown during rotation; ≥2.
- HOLD_CYCLES, 24_000_000: clock cycles a changed channel is shown in override; ≥2.
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- ch_value  in  N_CH*8  packed channel values; channel i at [8i+7:8i].
- ch_changed  in  N_CH  one-cycle pulse per channel when its value was modified.
- freeze  in  1  level; holds rotation on the current channel.
- disp_value  out  8  value for the seven-segment controller input.
- disp_sel  out  $clog2(N_CH)  index of the channel being shown.
- disp_override  out  1  high while in OVERRIDE.
- ch_led  out  N_CH  one-hot of disp_sel, for channel indicator LEDs.

## Operation
- Reset values: state ROTATE, disp_sel 0, disp_value 0x00, disp_override 0, ch_led 1, dwell_cnt 0, hold_cnt 0, pending 0.
- The arbitration request vector is req = pending | ch_changed. Round-robin grant is the first set bit of req, searching from disp_sel+1 upward and wrapping modulo N_CH. The search reaches disp_sel itself last.
- ROTATE state:
  - If req ≠ 0: disp_sel ← grant, state ← OVERRIDE, hold_cnt ← 0, clear pending[grant], dwell_cnt ← 0.
  - Else if freeze = 1: dwell_cnt and disp_sel hold.
  - Else if dwell_cnt = DWELL_CYCLES-1: dwell_cnt ← 0, disp_sel ← (disp_sel+1) mod N_CH. N_CH-1 wraps to 0, including non-power-of-2 N_CH.
  - Else dwell_cnt increments.
- OVERRIDE state:
  - ch_changed[disp_sel] restarts the hold (hold_cnt ← 0) and never sets pending.
  - ch_changed on any other channel sets the matching pending bit.
  - freeze is ignored.
  - At hold_cnt = HOLD_CYCLES-1 with the restart condition absent:
    - If (pending | other-channel ch_changed) ≠ 0: grant per round-robin, hold_cnt ← 0, clear that pending bit, stay in OVERRIDE.
    - Otherwise state ← ROTATE with dwell_cnt ← 0, keeping disp_sel.
  - Otherwise hold_cnt increments.
- Datapath:
  - disp_value ← ch_value slice at the current registered disp_sel, every cycle.
  - ch_led ← one-hot of the next disp_sel.
  - disp_override ← 1 exactly when the next state is OVERRIDE.
- Counter widths: $clog2 of the respective parameter. Counters never exceed parameter-1.

## Timing
- RST_N low clears all registers immediately, with no clock needed, including mid-override. The first state update is on the first rising edge after deassertion.
- ch_changed sampled at edge E in ROTATE: disp_sel, ch_led and disp_override update at E. disp_value shows the new channel at E+1.
- Edge-to-data latency:
  - ch_value change to disp_value: 1 cycle.
  - disp_sel change to disp_value: 1 cycle.
- Override lasts exactly HOLD_CYCLES edges per grant when there is no restart.
- During rotation each channel shows for exactly DWELL_CYCLES edges when freeze stays low.
- Simultaneous events:
  - A change request beats dwell expiry.
  - A restart on the current channel beats hold expiry.
  - ch_changed arriving in the same cycle as the grant of that same channel clears the pending bit; it does not re-set it.

## Structure
- Package disp_sched_pkg holds:
  - the state enum {ROTATE, OVERRIDE};
  - constant DISP_W = 8, the value width;
  - a function returning the one-hot of an index.
- Sub-module rr_pick is combinational. It takes N_CH, req and a base index, and returns grant index and valid. It is reusable for future display sources.

## Test plan
All scenarios use N_CH=3, DWELL_CYCLES=4, HOLD_CYCLES=6, and ch_value = {0x56, 0x34, 0x12}.
- Reset: RST_N low mid-run, no clock → disp_sel 0, disp_value 0x00, ch_led 001, disp_override 0.
- Rotation: no changes → disp_sel 0,1,2,0 every 4 cycles. disp_value 0x12→0x34→0x56→0x12, each one cycle after the disp_sel step.
- Freeze: freeze high at dwell_cnt 2 on channel 1 → disp_sel stays 1 for 20 cycles. After release, the advance comes 2 cycles later.
- Override: pulse ch_changed[2] while disp_sel=0 → disp_sel 2 on the same edge, disp_override high 6 cycles, disp_value 0x56. Then ROTATE, advancing to channel 0 after 4 more cycles.
- Contention: during ch2 override, pulse ch_changed[0] and ch_changed[1] together → after the hold, channel 0 for 6 cycles, then channel 1 for 6, then ROTATE.
- Restart: pulse ch_changed[2] at hold_cnt 4 → override extends to 6 cycles after that pulse, and pending stays 0.

Source files
------------

// File: rtl/disp_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_sched_pkg
// Brief    : Shared types, constants and helpers for the display scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package disp_sched_pkg;

  // Width of one displayed value (two seven-segment digits).
  localparam int DISP_W    = 8;
  // Upper bound on channel count and the index width that covers it.
  localparam int MAX_CH    = 8;
  localparam int MAX_IDX_W = 3;

  typedef enum logic [0:0] {
    ROTATE   = 1'b0,
    OVERRIDE = 1'b1
  } state_e;

  // One-hot of an index; callers size-cast the result down to their width.
  function automatic logic [MAX_CH-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker. Searches req from base+1
//            upward, wrapping modulo N_CH, so base itself is checked last.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N_CH  = 3,
  parameter int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [IDX_W-1:0] base_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             valid_o
);

  int w_idx;

  // First requesting index after base, wrapping; base is the last candidate.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N_CH; k++) begin
      w_idx = int'(base_i) + k;
      if (w_idx >= N_CH) w_idx = w_idx - N_CH;
      if (!valid_o && req_i[IDX_W'(w_idx)]) begin
        valid_o = 1'b1;
        grant_o = IDX_W'(w_idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : display_scheduler
// Brief    : Shares one two-digit display between channel values. Rotates on
//            a fixed dwell; a changed channel pre-empts rotation for a hold
//            period, with simultaneous changes served round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module display_scheduler
  import disp_sched_pkg::*;
#(
  parameter int N_CH         = 3,
  parameter int DWELL_CYCLES = 12_000_000,
  parameter int HOLD_CYCLES  = 24_000_000
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [N_CH*DISP_W-1:0]   ch_value_i,
  input  logic [N_CH-1:0]          ch_changed_i,
  input  logic                     freeze_i,
  output logic [DISP_W-1:0]        disp_value_o,
  output logic [$clog2(N_CH)-1:0]  disp_sel_o,
  output logic                     disp_override_o,
  output logic [N_CH-1:0]          ch_led_o
);

  localparam int SEL_W   = $clog2(N_CH);
  localparam int DWELL_W = $clog2(DWELL_CYCLES);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [N_CH-1:0]     pending_q, pending_d;
  logic [DISP_W-1:0]   value_q;
  logic                override_q;
  logic [N_CH-1:0]     led_q;

  logic [N_CH-1:0]     w_cur_oh;
  logic [N_CH-1:0]     w_other;
  logic                w_restart;
  logic [N_CH-1:0]     w_req;
  logic [SEL_W-1:0]    w_grant;
  logic                w_grant_valid;
  logic [N_CH-1:0]     w_grant_oh;

  assign w_cur_oh   = N_CH'(onehot(MAX_IDX_W'(sel_q)));
  assign w_other    = ch_changed_i & ~w_cur_oh;
  assign w_restart  = |(ch_changed_i & w_cur_oh);
  // In override the shown channel only restarts its hold, so it never requests.
  assign w_req      = (state_q == ROTATE) ? (pending_q | ch_changed_i)
                                          : (pending_q | w_other);
  assign w_grant_oh = N_CH'(onehot(MAX_IDX_W'(w_grant)));

  rr_pick #(
    .N_CH  (N_CH),
    .IDX_W (SEL_W)
  ) u_rr_pick (
    .req_i   (w_req),
    .base_i  (sel_q),
    .grant_o (w_grant),
    .valid_o (w_grant_valid)
  );

  // Next-state logic for the rotate/override scheduler.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    dwell_d   = dwell_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    case (state_q)
      ROTATE: begin
        if (w_grant_valid) begin
          state_d   = OVERRIDE;
          sel_d     = w_grant;
          hold_d    = '0;
          dwell_d   = '0;
          // Losers of a simultaneous change wait their turn in pending.
          pending_d = w_req & ~w_grant_oh;
        end else if (freeze_i) begin
          dwell_d = dwell_q;
        end else if (dwell_q == DWELL_W'(DWELL_CYCLES - 1)) begin
          dwell_d = '0;
          sel_d   = (sel_q == SEL_W'(N_CH - 1)) ? '0 : sel_q + SEL_W'(1);
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      OVERRIDE: begin
        pending_d = pending_q | w_other;
        if (w_restart) begin
          hold_d = '0;
        end else if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          if (w_grant_valid) begin
            sel_d     = w_grant;
            hold_d    = '0;
            pending_d = w_req & ~w_grant_oh;
          end else begin
            state_d = ROTATE;
            dwell_d = '0;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
    endcase
  end

  // State, counters and registered outputs; reset clears without a clock.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ROTATE;
      sel_q      <= '0;
      dwell_q    <= '0;
      hold_q     <= '0;
      pending_q  <= '0;
      value_q    <= '0;
      override_q <= 1'b0;
      led_q      <= N_CH'(1);
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      dwell_q    <= dwell_d;
      hold_q     <= hold_d;
      pending_q  <= pending_d;
      // Value follows the registered select, so it lags a select step by one.
      value_q    <= ch_value_i[{sel_q, 3'b000} +: DISP_W];
      override_q <= (state_d == OVERRIDE);
      led_q      <= N_CH'(onehot(MAX_IDX_W'(sel_d)));
    end
  end

  assign disp_value_o    = value_q;
  assign disp_sel_o      = sel_q;
  assign disp_override_o = override_q;
  assign ch_led_o        = led_q;

endmodule
`default_nettype wire
